// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU defines: load/store type encodings
// and data-bus transfer size codes.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } loadType_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } storeType_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load aligner: picks the addressed byte/half
// out of a raw bus word and extends it.
module mem_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rawData,
  input  logic [1:0]  offset,
  input  loadType_e   loadType,
  output logic [31:0] result
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Lane select and sign/zero extension
  always_comb begin
    byteVal = rawData[{offset, 3'b000} +: 8];
    halfVal = offset[1] ? rawData[31:16]
                        : rawData[15:0];
    result  = '0;
    unique case (loadType)
      LD_LB:   result = {{24{byteVal[7]}}, byteVal};
      LD_LBU:  result = {24'd0, byteVal};
      LD_LH:   result = {{16{halfVal[15]}}, halfVal};
      LD_LHU:  result = {16'd0, halfVal};
      LD_LW:   result = rawData;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller on an
// addr_ok/data_ok split-transaction bus.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_valid,
  input  logic              mem_wr,
  input  logic              mem_flush,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [2:0]        exe_load_type,
  input  logic [1:0]        exe_store_type,
  input  logic [DATA_W-1:0] exe_store_data,
  input  logic              exe_except,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] mem_load_data,
  output logic              mem_load_valid,
  output logic              mem_stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e state, nextState;

  loadType_e  ldType;
  storeType_e stType;
  logic       isLoad, isStore, capture;

  logic [1:0]        capSize;
  logic [DATA_W-1:0] capWdata;
  logic [3:0]        capWstrb;

  logic [ADDR_W-1:0] reqAddr;
  logic              reqWr;
  logic [1:0]        reqSize;
  logic [DATA_W-1:0] reqWdata;
  logic [3:0]        reqWstrb;
  loadType_e         reqLoad;

  logic [DATA_W-1:0] alignResult;
  logic [DATA_W-1:0] loadData;
  logic              loadDone;

  assign ldType  = loadType_e'(exe_load_type);
  assign stType  = storeType_e'(exe_store_type);
  assign isLoad  = ldType != LD_NONE;
  assign isStore = stType != ST_NONE;

  assign capture = (state == S_IDLE || state == S_DONE)
                 & mem_wr & exe_valid & !exe_except
                 & !mem_flush & (isLoad | isStore);

  // Store lane replication and size for the new request
  always_comb begin
    capSize  = SIZE_WORD;
    capWdata = '0;
    capWstrb = '0;
    unique case (stType)
      ST_SB: begin
        capSize  = SIZE_BYTE;
        capWdata = {4{exe_store_data[7:0]}};
        capWstrb = 4'b0001 << exe_addr[1:0];
      end
      ST_SH: begin
        capSize  = SIZE_HALF;
        capWdata = {2{exe_store_data[15:0]}};
        capWstrb = exe_addr[1] ? 4'b1100 : 4'b0011;
      end
      ST_SW: begin
        capSize  = SIZE_WORD;
        capWdata = exe_store_data;
        capWstrb = 4'b1111;
      end
      default: begin
        unique case (ldType)
          LD_LB, LD_LBU: capSize = SIZE_BYTE;
          LD_LH, LD_LHU: capSize = SIZE_HALF;
          default:       capSize = SIZE_WORD;
        endcase
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nextState;
  end

  // Next state; flush takes priority over progress
  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE: begin
        if (capture) nextState = S_REQ;
      end
      S_REQ: begin
        if (mem_flush)
          nextState = data_addr_ok ? S_DRAIN : S_IDLE;
        else if (data_addr_ok)
          nextState = S_WAIT;
      end
      S_WAIT: begin
        if (mem_flush)
          nextState = data_data_ok ? S_IDLE : S_DRAIN;
        else if (data_data_ok)
          nextState = S_DONE;
      end
      S_DONE: begin
        if (mem_flush)
          nextState = S_IDLE;
        else if (mem_wr)
          nextState = capture ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (data_data_ok) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Request fields, frozen from capture until the next one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reqAddr  <= '0;
      reqWr    <= 1'b0;
      reqSize  <= '0;
      reqWdata <= '0;
      reqWstrb <= '0;
      reqLoad  <= LD_NONE;
    end else if (capture) begin
      reqAddr  <= exe_addr;
      reqWr    <= isStore;
      reqSize  <= capSize;
      reqWdata <= capWdata;
      reqWstrb <= capWstrb;
      reqLoad  <= isStore ? LD_NONE : ldType;
    end
  end

  mem_load_align uAlign (
    .rawData  (data_rdata),
    .offset   (reqAddr[1:0]),
    .loadType (reqLoad),
    .result   (alignResult)
  );

  assign loadDone = (state == S_WAIT) & data_data_ok
                  & !mem_flush & (reqLoad != LD_NONE);

  // Load result register, held through DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       loadData <= '0;
    else if (loadDone) loadData <= alignResult;
  end

  assign data_req       = state == S_REQ;
  assign data_wr        = reqWr;
  assign data_size      = reqSize;
  assign data_addr      = reqAddr;
  assign data_wdata     = reqWdata;
  assign data_wstrb     = reqWstrb;
  assign mem_load_data  = loadData;
  assign mem_load_valid = state == S_DONE;
  assign mem_stall      = state == S_REQ
                        || state == S_WAIT
                        || state == S_DRAIN;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl
// with a behavioural load/store lane model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_valid, mem_wr, mem_flush;
  logic [31:0] exe_addr;
  logic [2:0]  exe_load_type;
  logic [1:0]  exe_store_type;
  logic [31:0] exe_store_data;
  logic        exe_except;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_load_data;
  logic        mem_load_valid, mem_stall;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .exe_valid      (exe_valid),
    .mem_wr         (mem_wr),
    .mem_flush      (mem_flush),
    .exe_addr       (exe_addr),
    .exe_load_type  (exe_load_type),
    .exe_store_type (exe_store_type),
    .exe_store_data (exe_store_data),
    .exe_except     (exe_except),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_wstrb     (data_wstrb),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .mem_load_data  (mem_load_data),
    .mem_load_valid (mem_load_valid),
    .mem_stall      (mem_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, ".req"},   32'(data_req),       0);
    chk({tag, ".wr"},    32'(data_wr),        0);
    chk({tag, ".size"},  32'(data_size),      0);
    chk({tag, ".addr"},  data_addr,           0);
    chk({tag, ".wdata"}, data_wdata,          0);
    chk({tag, ".wstrb"}, 32'(data_wstrb),     0);
    chk({tag, ".ldata"}, mem_load_data,       0);
    chk({tag, ".valid"}, 32'(mem_load_valid), 0);
    chk({tag, ".stall"}, 32'(mem_stall),      0);
  endtask

  // Reference: load result from raw word, by type code
  function automatic logic [31:0] refLoad(
      input int ty, input logic [31:0] a,
      input logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    v   = rd;
    if (ty == 1 || ty == 2) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (ty == 1 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (ty == 3 || ty == 4) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (ty == 3 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic int refSize(input bit st,
                                 input int ty);
    if (st) return ty - 1;
    if (ty <= 2) return 0;
    if (ty <= 4) return 1;
    return 2;
  endfunction

  function automatic int refStrb(input bit st,
      input int ty, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (!st) return 0;
    if (ty == 1) return 1 << off;
    if (ty == 2) return (off >= 2) ? 12 : 3;
    return 15;
  endfunction

  function automatic logic [31:0] refWdata(
      input int ty, input logic [31:0] d);
    if (ty == 1) return (d % 256) * 32'h0101_0101;
    if (ty == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic issue(input bit st, input int ty,
                       input logic [31:0] a,
                       input logic [31:0] d);
    exe_valid      = 1'b1;
    mem_wr         = 1'b1;
    exe_addr       = a;
    exe_store_data = d;
    exe_load_type  = st ? 3'd0 : 3'(ty);
    exe_store_type = st ? 2'(ty) : 2'd0;
    tick();
    exe_valid      = 1'b0;
    exe_load_type  = 3'd0;
    exe_store_type = 2'd0;
  endtask

  task automatic runTxn(input bit st, input int ty,
      input logic [31:0] a, input logic [31:0] d,
      input logic [31:0] rd, input int okD,
      input int dD, input string tag);
    chk({tag, ".preStall"}, 32'(mem_stall), 0);
    issue(st, ty, a, d);
    for (int k = 0; k <= okD; k++) begin
      chk({tag, ".req"},   32'(data_req),   1);
      chk({tag, ".stallR"}, 32'(mem_stall), 1);
      chk({tag, ".addr"},  data_addr,       a);
      chk({tag, ".wr"},    32'(data_wr),    32'(st));
      chk({tag, ".size"},  32'(data_size),
          32'(refSize(st, ty)));
      chk({tag, ".wstrb"}, 32'(data_wstrb),
          32'(refStrb(st, ty, a)));
      if (st)
        chk({tag, ".wdata"}, data_wdata,
            refWdata(ty, d));
      if (k == okD) data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
    end
    for (int k = 0; k <= dD; k++) begin
      chk({tag, ".reqW"},   32'(data_req),  0);
      chk({tag, ".stallW"}, 32'(mem_stall), 1);
      if (k == dD) begin
        data_data_ok = 1'b1;
        data_rdata   = rd;
      end
      tick();
      data_data_ok = 1'b0;
    end
    chk({tag, ".valid"},  32'(mem_load_valid), 1);
    chk({tag, ".stallD"}, 32'(mem_stall),      0);
    if (!st)
      chk({tag, ".ldata"}, mem_load_data,
          refLoad(ty, a, rd));
  endtask

  initial begin
    resetn         = 1'b1;
    exe_valid      = 1'b0;
    mem_wr         = 1'b0;
    mem_flush      = 1'b0;
    exe_addr       = '0;
    exe_load_type  = '0;
    exe_store_type = '0;
    exe_store_data = '0;
    exe_except     = 1'b0;
    data_addr_ok   = 1'b0;
    data_data_ok   = 1'b0;
    data_rdata     = '0;
    #2 resetn = 1'b0;
    #1 chkZero("reset");
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // LB sign-extended at offset 3, then hold in DONE
    runTxn(0, 1, 32'h1003, 0, 32'h80FF_1234,
           0, 0, "lb");
    chk("lb.exact", mem_load_data, 32'hFFFF_FF80);
    mem_wr = 1'b0;
    tick();
    chk("hold.valid", 32'(mem_load_valid), 1);
    chk("hold.data",  mem_load_data, 32'hFFFF_FF80);
    mem_wr = 1'b1;
    tick();
    chk("release.valid", 32'(mem_load_valid), 0);

    // SH upper half
    runTxn(1, 2, 32'h2002, 32'h0000_BEEF, 0,
           0, 0, "sh");
    chk("sh.wdata", data_wdata, 32'hBEEF_BEEF);
    chk("sh.wstrb", 32'(data_wstrb), 32'hC);

    // addr_ok held off for 3 cycles (DONE -> REQ)
    runTxn(1, 3, 32'h4000, 32'h1234_5678, 0,
           3, 1, "swStall");

    // Flush in DONE clears valid
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    chk("flushDone.valid", 32'(mem_load_valid), 0);

    // Flush in WAIT without data_ok -> DRAIN
    issue(0, 5, 32'h3000, 0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    chk("drain.stall", 32'(mem_stall), 1);
    chk("drain.req",   32'(data_req),  0);
    exe_valid     = 1'b1;
    exe_load_type = 3'd5;
    tick();
    exe_valid     = 1'b0;
    exe_load_type = 3'd0;
    chk("drain.noCap", 32'(data_req),  0);
    chk("drain.hold",  32'(mem_stall), 1);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    tick();
    data_data_ok = 1'b0;
    chk("drain.exitStall", 32'(mem_stall), 0);
    chk("drain.exitValid", 32'(mem_load_valid), 0);
    runTxn(0, 5, 32'h3004, 0, 32'h1234_5678,
           1, 2, "lwAfterDrain");
    chk("lwAfterDrain.exact", mem_load_data,
        32'h1234_5678);

    // Flush in WAIT with data_ok: data discarded
    mem_wr = 1'b1;
    tick();
    issue(0, 1, 32'h5001, 0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    mem_flush    = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hAAAA_AAAA;
    tick();
    mem_flush    = 1'b0;
    data_data_ok = 1'b0;
    chk("flushWaitOk.stall", 32'(mem_stall), 0);
    chk("flushWaitOk.valid", 32'(mem_load_valid), 0);
    chk("flushWaitOk.data", mem_load_data,
        32'h1234_5678);

    // Flush in REQ without addr_ok withdraws
    issue(1, 3, 32'h6000, 32'h5555_0000);
    chk("flushReq.reqBefore", 32'(data_req), 1);
    mem_flush = 1'b1;
    tick();
    mem_flush = 1'b0;
    chk("flushReq.req",   32'(data_req),  0);
    chk("flushReq.stall", 32'(mem_stall), 0);

    // Exception suppresses the access
    exe_except = 1'b1;
    issue(0, 5, 32'h7000, 0);
    exe_except = 1'b0;
    chk("except.req",   32'(data_req),  0);
    chk("except.stall", 32'(mem_stall), 0);
    tick();
    chk("except.req2",   32'(data_req),  0);
    chk("except.stall2", 32'(mem_stall), 0);

    // Async reset while in WAIT
    issue(0, 5, 32'h8000, 0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("rstWait.stallPre", 32'(mem_stall), 1);
    #2 resetn = 1'b0;
    #1 chkZero("rstWait");
    @(posedge clk);
    #1 resetn = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    tick();
    data_data_ok = 1'b0;
    chkZero("rstWait.after");

    // Randomized transactions, back to back
    for (int i = 0; i < 30; i++) begin
      bit st;
      int ty;
      st = 1'($urandom_range(0, 1));
      ty = st ? int'($urandom_range(1, 3))
              : int'($urandom_range(1, 5));
      runTxn(st, ty, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), "rnd");
    end
    mem_wr = 1'b1;
    tick();
    chk("final.valid", 32'(mem_load_valid), 0);
    chk("final.stall", 32'(mem_stall),      0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
